// File: rtl/cp0_irq_pkg.sv
// cp0_irq_pkg: register map, field positions and priority encoder shared by cp0_irq
package cp0_irq_pkg;
  localparam logic [3:0] ADDR_IER = 4'd0;
  localparam logic [3:0] ADDR_IPR = 4'd1;
  localparam logic [3:0] ADDR_IMR = 4'd2;
  localparam logic [3:0] ADDR_ISR = 4'd3;
  localparam logic [3:0] ADDR_TIR = 4'd4;
  localparam int GIE = 31;
  localparam int PGIE = 30;
  localparam int ISR_VALID = 31;
  localparam int TIR_PER = 31;
  localparam int TIR_MS_MSB = 15;
  function automatic logic [4:0] prio_enc(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 31; i >= 0; i--) if (v[i]) r = 5'(i);
    return r;
  endfunction
endpackage

// File: rtl/cp0_irq_timer.sv
// cp0_irq_timer: one ms counter with period/mode register and expiry pulse
module cp0_irq_timer import cp0_irq_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic        wr_en_i,
  input  logic        per_i,
  input  logic [15:0] prd_i,
  output logic [31:0] tir_o,
  output logic        expire_o
);
  logic        per_q, per_d;
  logic [15:0] prd_q, prd_d, cnt_q, cnt_d;
  logic        run;
  assign run = tick_i && prd_q != 16'd0;
  assign expire_o = run && !wr_en_i && cnt_q == prd_q - 16'd1;
  assign tir_o = {per_q, 15'b0, prd_q};
  always_comb begin
    per_d = wr_en_i ? per_i : per_q;
    prd_d = wr_en_i ? prd_i : (expire_o && !per_q) ? 16'd0 : prd_q;
    cnt_d = (wr_en_i || expire_o) ? 16'd0 : run ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      per_q <= 1'b0;
      prd_q <= '0;
      cnt_q <= '0;
    end else begin
      per_q <= per_d;
      prd_q <= prd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cp0_irq.sv
// cp0_irq: CP0-side interrupt/timer unit with edge/level channels and prioritised request
module cp0_irq import cp0_irq_pkg::*; #(
  parameter int IRQ_NUM   = 24,
  parameter int TIMER_NUM = 2,
  parameter int CLK_FREQ  = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] ir_map,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         rd_addr,
  output logic [31:0]        rd_data,
  input  logic               irq_ack,
  input  logic               irq_ret,
  output logic               irq_req,
  output logic [4:0]         irq_id
);
  localparam int CH_NUM = IRQ_NUM + TIMER_NUM;
  localparam int PRE_N = CLK_FREQ * 1000;
  localparam int PW = $clog2(PRE_N);
  logic [PW-1:0] pre_q;
  logic tick, w_ier, w_ipr, w_imr;
  logic [IRQ_NUM-1:0] s1_q, s2_q, s3_q, imr_q, imr_d;
  logic [CH_NUM-1:0] ipr_q, ipr_d, en_q, en_d, edge_m, lvl, set_v, clr, act;
  logic gie_q, gie_d, pgie_q, pgie_d, isr_v_q, req_d;
  logic [4:0] isr_id_q, isr_id_d, id_d;
  logic [TIMER_NUM-1:0] exp_t;
  logic [31:0] tir [TIMER_NUM];
  logic unused_wr;
  assign unused_wr = ^wr_data;
  assign tick = pre_q == PW'(PRE_N - 1);
  assign w_ier = wr_en && wr_addr == ADDR_IER;
  assign w_ipr = wr_en && wr_addr == ADDR_IPR;
  assign w_imr = wr_en && wr_addr == ADDR_IMR;
  assign edge_m = {imr_q, {TIMER_NUM{1'b1}}};
  assign act = ipr_q & en_q;
  for (genvar t = 0; t < TIMER_NUM; t++) begin : g_tmr
    cp0_irq_timer u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick),
      .wr_en_i  (wr_en && wr_addr == 4'(ADDR_TIR + t)),
      .per_i    (wr_data[TIR_PER]),
      .prd_i    (wr_data[TIR_MS_MSB:0]),
      .tir_o    (tir[t]),
      .expire_o (exp_t[t])
    );
  end
  // Edge bits hold until cleared; a simultaneous set beats the write-1-clear.
  always_comb begin
    lvl = {s2_q, {TIMER_NUM{1'b0}}};
    set_v = {s2_q & ~s3_q, exp_t};
    clr = w_ipr ? wr_data[CH_NUM-1:0] : '0;
    ipr_d = (edge_m & (set_v | (ipr_q & ~clr))) | (~edge_m & lvl);
    en_d = w_ier ? wr_data[CH_NUM-1:0] : en_q;
    imr_d = w_imr ? wr_data[CH_NUM-1:TIMER_NUM] : imr_q;
    gie_d = irq_ack ? 1'b0 : irq_ret ? pgie_q : w_ier ? wr_data[GIE] : gie_q;
    pgie_d = irq_ack ? gie_q : (w_ier && !irq_ret) ? wr_data[PGIE] : pgie_q;
    isr_id_d = irq_ack ? irq_id : isr_id_q;
    req_d = gie_q && |act;
    id_d = prio_enc(32'(act));
  end
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_IER: rd_data = {gie_q, pgie_q, 30'(en_q)};
      ADDR_IPR: rd_data = 32'(ipr_q);
      ADDR_IMR: rd_data = 32'(edge_m);
      ADDR_ISR: rd_data = {isr_v_q, 26'b0, isr_id_q};
      default: for (int i = 0; i < TIMER_NUM; i++) if (rd_addr == 4'(ADDR_TIR + i)) rd_data = tir[i];
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      imr_q <= '0;
      ipr_q <= '0;
      en_q <= '0;
      gie_q <= 1'b0;
      pgie_q <= 1'b0;
      isr_v_q <= 1'b0;
      isr_id_q <= '0;
      irq_req <= 1'b0;
      irq_id <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      s1_q <= ir_map;
      s2_q <= s1_q;
      s3_q <= s2_q;
      imr_q <= imr_d;
      ipr_q <= ipr_d;
      en_q <= en_d;
      gie_q <= gie_d;
      pgie_q <= pgie_d;
      isr_v_q <= isr_v_q | irq_ack;
      isr_id_q <= isr_id_d;
      irq_req <= req_d;
      irq_id <= id_d;
    end
endmodule

// File: tb/tb_cp0_irq.sv
// tb_cp0_irq: scoreboard bench; stimulus queues expected irq events and reads, a monitor checks them
module tb_cp0_irq;
  import cp0_irq_pkg::*;
  logic clk = 0, rst_n, wr_en, irq_ack, irq_ret, irq_req;
  logic [23:0] ir_map;
  logic [3:0] wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [4:0] irq_id;
  cp0_irq #(.IRQ_NUM(24), .TIMER_NUM(2), .CLK_FREQ(1)) dut (
    .clk(clk), .rst_n(rst_n), .ir_map(ir_map), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .irq_ack(irq_ack),
    .irq_ret(irq_ret), .irq_req(irq_req), .irq_id(irq_id)
  );
  always #5 clk = ~clk;
  typedef struct {logic req; logic [4:0] id; int at;} ev_t;
  typedef struct {string name; logic [31:0] exp; bit out;} rd_t;
  ev_t evq[$];
  rd_t rdq[$];
  ev_t e;
  rd_t r;
  logic [31:0] got;
  logic [5:0] prev = 6'b0;
  int cyc = 0, r0 = 0, checks = 0, errors = 0, w, t;
  bit rd_stb, done, fin;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if ({irq_req, irq_id} !== prev) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL irq_event: got req=%0b id=%0d at cyc %0d, required no change", irq_req, irq_id, cyc);
      end else begin
        e = evq.pop_front();
        if (irq_req !== e.req || irq_id !== e.id || cyc != e.at) begin
          errors++;
          $display("FAIL irq_event: got req=%0b id=%0d at cyc %0d, required req=%0b id=%0d at cyc %0d",
                   irq_req, irq_id, cyc, e.req, e.id, e.at);
        end
      end
      prev = {irq_req, irq_id};
    end
    if (rd_stb) begin
      r = rdq.pop_front();
      got = r.out ? {26'b0, irq_req, irq_id} : rd_data;
      checks++;
      if (got !== r.exp) begin
        errors++;
        $display("FAIL %s: got %h, required %h", r.name, got, r.exp);
      end
    end
    if (done && !fin) begin
      fin = 1;
      checks++;
      if (evq.size() != 0 || rdq.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d events %0d reads pending, required 0", evq.size(), rdq.size());
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_n(input int n);
    repeat (n) step();
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask
  task automatic rd_chk(input logic [3:0] a, input logic [31:0] x, input string n, input bit o = 1'b0);
    rd_addr = a;
    rdq.push_back('{name: n, exp: x, out: o});
    rd_stb = 1;
    step();
    rd_stb = 0;
  endtask
  task automatic ev(input logic q, input logic [4:0] i, input int c);
    evq.push_back('{req: q, id: i, at: c});
  endtask
  function automatic int next_tick(input int x);
    int k;
    k = r0 + 1000;
    while (k < x) k += 1000;
    return k;
  endfunction
  initial begin
    rst_n = 0; ir_map = '0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    irq_ack = 0; irq_ret = 0; rd_stb = 0; done = 0; fin = 0;
    wait_n(3);
    rst_n = 1; r0 = cyc;
    rd_chk(4'd0, 32'h0, "out_reset", 1'b1);
    rd_chk(ADDR_IER, 32'h0, "ier_reset");
    rd_chk(ADDR_IPR, 32'h0, "ipr_reset");
    rd_chk(ADDR_IMR, 32'h3, "imr_reset");
    rd_chk(ADDR_ISR, 32'h0, "isr_reset");
    rd_chk(4'd4, 32'h0, "tir0_reset");
    rd_chk(4'd15, 32'h0, "unmapped");
    // level channel 2
    wr(ADDR_IER, 32'h8000_0004);
    ir_map[0] = 1; ev(1, 2, cyc + 4); wait_n(6);
    ir_map[0] = 0; ev(0, 0, cyc + 4); wait_n(6);
    // edge channels 2 and 5 rising together
    wr(ADDR_IMR, 32'h24);
    rd_chk(ADDR_IMR, 32'h27, "imr_edge");
    wr(ADDR_IER, 32'h8000_0024);
    ir_map[0] = 1; ir_map[3] = 1; ev(1, 2, cyc + 4); wait_n(6);
    ev(1, 5, cyc + 2); wr(ADDR_IPR, 32'h4);
    rd_chk(ADDR_IPR, 32'h20, "ipr_after_clr");
    ev(0, 0, cyc + 2); wr(ADDR_IPR, 32'h20);
    ir_map = '0; wait_n(4);
    // set beats write-1-clear on channel 4
    wr(ADDR_IMR, 32'h34); wr(ADDR_IER, 32'h0);
    ir_map[2] = 1; wait_n(2); wr(ADDR_IPR, 32'h10);
    rd_chk(ADDR_IPR, 32'h10, "ipr_set_wins");
    wr(ADDR_IPR, 32'h10);
    rd_chk(ADDR_IPR, 32'h0, "ipr_w1c");
    ir_map[2] = 0;
    // ack / ret on channel 3 (level)
    wr(ADDR_IER, 32'h8000_0008);
    ir_map[1] = 1; ev(1, 3, cyc + 4); wait_n(6);
    wr(ADDR_IPR, 32'h8);
    rd_chk(ADDR_IPR, 32'h8, "ipr_level_ignores_w1c");
    ev(0, 3, cyc + 2); irq_ack = 1; step(); irq_ack = 0;
    rd_chk(ADDR_IER, 32'h4000_0008, "ier_after_ack");
    rd_chk(ADDR_ISR, 32'h8000_0003, "isr_after_ack");
    ev(1, 3, cyc + 2); irq_ret = 1; step(); irq_ret = 0;
    rd_chk(ADDR_IER, 32'hC000_0008, "ier_after_ret");
    ir_map[1] = 0; ev(0, 0, cyc + 4); wait_n(6);
    // ack/ret alongside an IER write
    irq_ack = 1; wr(ADDR_IER, 32'h0000_0010); irq_ack = 0;
    rd_chk(ADDR_IER, 32'h4000_0010, "ier_ack_with_write");
    irq_ret = 1; wr(ADDR_IER, 32'h0000_0008); irq_ret = 0;
    rd_chk(ADDR_IER, 32'hC000_0008, "ier_ret_with_write");
    // periodic timer 0, then one-shot
    wr(ADDR_IER, 32'h8000_0001);
    w = cyc; wr(4'd4, 32'h8000_0003);
    t = next_tick(w + 2) + 2000; ev(1, 0, t + 1);
    wait_until(t + 3);
    rd_chk(ADDR_IPR, 32'h1, "ipr_timer");
    ev(0, 0, cyc + 2); wr(ADDR_IPR, 32'h1);
    ev(1, 0, t + 3001); wait_until(t + 3003);
    ev(0, 0, cyc + 2); wr(ADDR_IPR, 32'h1);
    w = cyc; wr(4'd4, 32'h2);
    t = next_tick(w + 2) + 1000; ev(1, 0, t + 1);
    wait_until(t + 3);
    rd_chk(4'd4, 32'h0, "tir0_oneshot_cleared");
    ev(0, 0, cyc + 2); wr(ADDR_IPR, 32'h1);
    wait_n(3500);
    rd_chk(ADDR_IPR, 32'h0, "ipr_no_more_expiry");
    // reset mid-count with request active
    w = cyc; wr(4'd4, 32'h8000_0003);
    t = next_tick(w + 2) + 2000; ev(1, 0, t + 1);
    wait_until(t + 300);
    ev(0, 0, cyc); rst_n = 0;
    rd_chk(4'd0, 32'h0, "out_in_reset", 1'b1);
    rd_chk(4'd4, 32'h0, "tir0_in_reset");
    rd_chk(ADDR_IER, 32'h0, "ier_in_reset");
    rst_n = 1; r0 = cyc;
    wr(ADDR_IER, 32'h8000_0001);
    wait_n(4000);
    rd_chk(ADDR_IPR, 32'h0, "ipr_no_expiry_after_reset");
    rd_chk(4'd4, 32'h0, "tir0_after_reset");
    done = 1;
    wait_n(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
